// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: 32-cycle shift-add multiply or restoring
// divide on operand magnitudes, a one-cycle sign fix-up, valid/ready result port.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [OP_W-1:0]  op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o
);

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(20);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(22);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(24);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(26);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(27);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic                div_q, rem_q, lo_q, a_neg_q, b_neg_q;
  logic [XLEN-1:0]     opb;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod;  // product; low half doubles as dividend/quotient
  logic [XLEN-1:0]     rem;

  // request decode
  logic            req_md, req_div, req_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, req_special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign req_md  = (op_i >= OP_MUL) && (op_i <= OP_REMU);
  assign req_div = op_i >= OP_DIV;
  assign req_rem = (op_i == OP_REM) || (op_i == OP_REMU);
  assign b_sgn   = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_sgn   = b_sgn || (op_i == OP_MULHSU);
  assign a_neg   = a_sgn & rs1_i[XLEN-1];
  assign b_neg   = b_sgn & rs2_i[XLEN-1];
  assign a_mag   = a_neg ? -rs1_i : rs1_i;
  assign b_mag   = b_neg ? -rs2_i : rs2_i;

  // divide-by-zero and INT_MIN/-1 bypass the iteration entirely
  assign div_zero    = req_div && (rs2_i == {XLEN{1'b0}});
  assign div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (rs1_i == INT_MIN) && (rs2_i == {XLEN{1'b1}});
  assign req_special = div_zero || div_ovf;
  assign special_res = div_zero ? (req_rem ? rs1_i : {XLEN{1'b1}})
                                : (req_rem ? {XLEN{1'b0}} : INT_MIN);

  // one iteration of either algorithm
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign div_shift = {rem, prod[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_sub   = div_shift[XLEN-1:0] - opb;  // fits: difference is below the divisor

  // sign fix-up; the quotient is the low half of the (possibly negated) register
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix, fix_res;

  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
  assign rem_fix  = a_neg_q ? -rem : rem;
  assign fix_res  = div_q ? (rem_q ? rem_fix : prod_fix[XLEN-1:0])
                          : (lo_q ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i && req_md) begin
          rd_o    <= rd_i;
          div_q   <= req_div;
          rem_q   <= req_rem;
          lo_q    <= (op_i == OP_MUL);
          a_neg_q <= a_neg;
          b_neg_q <= b_neg;
          opb     <= req_div ? b_mag : a_mag;
          prod    <= {{XLEN{1'b0}}, req_div ? a_mag : b_mag};
          rem     <= '0;
          cnt     <= '0;
          if (req_special) begin
            result_o <= special_res;
            valid_o  <= 1'b1;
            state    <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (div_q) begin
            rem             <= div_ge ? div_sub : div_shift[XLEN-1:0];
            prod[XLEN-1:0]  <= {prod[XLEN-2:0], div_ge};
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          result_o <= fix_res;
          valid_o  <= 1'b1;
          state    <= DONE;
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Random + directed bench for muldiv_unit: a transaction-level reference model
// predicts ready/valid/result every cycle; literal checks pin the model.
module tb_muldiv_unit;

  logic        clk, rst, flush_i, valid_i, ready_o, valid_o, ready_i;
  logic [5:0]  op_i;
  logic [31:0] rs1_i, rs2_i, result_o;
  logic [4:0]  rd_i, rd_o;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // architectural result of an RV32M op, straight from the ISA definition
  function automatic logic [31:0] ref_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, p;
    int sa, sb;
    if (op <= 6'd23) begin
      a64 = (op != 6'd23 && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
      b64 = (op <= 6'd21 && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
      p = a64 * b64;
      return (op == 6'd20) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return (op == 6'd24 || op == 6'd25) ? 32'hFFFFFFFF : a;
    if (op == 6'd24 || op == 6'd26) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return (op == 6'd24) ? 32'h80000000 : 32'h0;
      sa = a;
      sb = b;
      return (op == 6'd24) ? sa / sb : sa % sb;
    end
    return (op == 6'd25) ? a / b : a % b;
  endfunction

  function automatic bit is_special(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 6'd24) && (b == 32'h0 ||
           ((op == 6'd24 || op == 6'd26) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // transaction model: busy for 33 edges after acceptance, then holds a result
  bit          armed = 0, m_busy = 0, m_done = 0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      armed  <= 1;
      m_busy <= 0;
      m_done <= 0;
    end else if (flush_i) begin
      m_busy <= 0;
      m_done <= 0;
    end else if (m_done) begin
      if (ready_i) m_done <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 0;
        m_done <= 1;
      end
    end else if (valid_i && op_i >= 6'd20 && op_i <= 6'd27) begin
      m_res <= ref_md(op_i, rs1_i, rs2_i);
      m_rd  <= rd_i;
      if (is_special(op_i, rs1_i, rs2_i)) m_done <= 1;
      else begin
        m_busy <= 1;
        m_cnt  <= 33;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("ready_o", ready_o, !m_busy && !m_done);
      chk("valid_o", valid_o, m_done);
      if (m_done) begin
        chk("result_o", result_o, m_res);
        chk("rd_o", rd_o, m_rd);
      end
    end
  end

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int hold);
    int n;
    @(negedge clk);
    valid_i = 1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; ready_i = 0;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0;
    n = 0;
    while (!valid_o && n < 60) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    repeat (hold) begin
      valid_i = 1; op_i = 6'd20; rs1_i = $urandom; rd_i = 5'd31;
      @(posedge clk); @(negedge clk);
    end
    valid_i = 0; ready_i = 1;
    @(posedge clk); @(negedge clk);
    ready_i = 0;
  endtask

  // start a DIV, then hit it with flush (kind 0) or reset (kind 1) after `edges`
  task automatic abort_op(input int kind, input int edges);
    int rises;
    @(negedge clk);
    valid_i = 1; op_i = 6'd24; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd9;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0;
    repeat (edges - 1) @(posedge clk);
    @(negedge clk);
    if (kind == 0) begin
      flush_i = 1; valid_i = 1; op_i = 6'd25;
    end else rst = 1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 0; valid_i = 0; rst = 0;
    chk(kind == 0 ? "flush_ready" : "rst_ready", ready_o, 1);
    if (kind == 1) begin
      chk("rst_result", result_o, 0);
      chk("rst_rd", rd_o, 0);
    end
    rises = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (valid_o) rises++;
    end
    chk(kind == 0 ? "flush_no_valid" : "rst_no_valid", rises, 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    rst = 1; flush_i = 0; valid_i = 0; ready_i = 0;
    op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result_o, 0);
    chk("reset_rd", rd_o, 0);
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    rst = 0;

    chk("model_mul", ref_md(6'd20, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mulh", ref_md(6'd21, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("model_mulhu", ref_md(6'd23, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("model_mulhsu", ref_md(6'd22, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("model_mul_min", ref_md(6'd20, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("model_div", ref_md(6'd24, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("model_rem", ref_md(6'd26, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model_rem_negdiv", ref_md(6'd26, 32'd7, 32'hFFFFFFFE), 32'd1);
    chk("model_divu", ref_md(6'd25, 32'd100, 32'd7), 32'd14);
    chk("model_remu", ref_md(6'd27, 32'd100, 32'd7), 32'd2);
    chk("model_div0", ref_md(6'd24, 32'd5, 32'd0), 32'hFFFFFFFF);
    chk("model_rem0", ref_md(6'd26, 32'd5, 32'd0), 32'd5);
    chk("model_ovf_div", ref_md(6'd24, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("model_ovf_rem", ref_md(6'd26, 32'h80000000, 32'hFFFFFFFF), 32'd0);

    run_op(6'd20, 32'd7, 32'hFFFFFFFD, 5'd3, 33, 0);
    run_op(6'd21, 32'h80000000, 32'h80000000, 5'd4, 33, 0);
    run_op(6'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 33, 0);
    run_op(6'd22, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 33, 0);
    run_op(6'd20, 32'h80000000, 32'hFFFFFFFF, 5'd7, 33, 0);
    run_op(6'd24, 32'hFFFFFFF9, 32'd2, 5'd8, 33, 0);
    run_op(6'd26, 32'hFFFFFFF9, 32'd2, 5'd9, 33, 0);
    run_op(6'd26, 32'd7, 32'hFFFFFFFE, 5'd10, 33, 0);
    run_op(6'd25, 32'd100, 32'd7, 5'd11, 33, 5);
    run_op(6'd27, 32'd100, 32'd7, 5'd12, 33, 0);
    run_op(6'd24, 32'd5, 32'd0, 5'd13, 0, 0);
    run_op(6'd26, 32'd5, 32'd0, 5'd14, 0, 5);
    run_op(6'd24, 32'h80000000, 32'hFFFFFFFF, 5'd15, 0, 0);
    run_op(6'd26, 32'h80000000, 32'hFFFFFFFF, 5'd16, 0, 0);

    // non-M opcode is dropped
    @(negedge clk);
    valid_i = 1; op_i = 6'd10; rs1_i = 32'd1; rs2_i = 32'd2;
    @(posedge clk); @(negedge clk);
    valid_i = 0;
    chk("add_ignored_ready", ready_o, 1);
    chk("add_ignored_valid", valid_o, 0);

    abort_op(0, 10);
    abort_op(1, 20);

    // flush while a result waits in DONE
    @(negedge clk);
    valid_i = 1; op_i = 6'd25; rs1_i = 32'd50; rs2_i = 32'd0; rd_i = 5'd2;
    @(posedge clk); @(negedge clk);
    valid_i = 0;
    chk("done_before_flush", valid_o, 1);
    flush_i = 1;
    @(posedge clk); @(negedge clk);
    flush_i = 0;
    chk("done_flush_valid", valid_o, 0);
    chk("done_flush_ready", ready_o, 1);

    for (int i = 0; i < 200; i++) begin
      op = 6'(20 + $urandom_range(0, 7));
      a = rnd_opnd();
      b = rnd_opnd();
      run_op(op, a, b, 5'($urandom), is_special(op, a, b) ? 0 : 33, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
